// File: rtl/div11_rr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div11_rr_scheduler_pkg
// Description : Shared constants and helpers for the divisible-by-11
//               round-robin scheduler slice.
//               W        - data word width, fixed by the checker input width
//               DIV_MOD  - divisor, used by reference models only
//               id_w()   - requester-id width, clog2(n) with a floor of 1
// Revision    : 1.0 - initial release
// ============================================================================
package div11_rr_scheduler_pkg;

  localparam int W       = 16;
  localparam int DIV_MOD = 11;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div11_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : div11_rr_scheduler_if
// Description : Requester and result bundle of the scheduler.
//               req_valid/req_data/req_ready - NREQ requester handshakes
//               res_*                        - single result slot + handshake
//               hit_count, busy              - status
//               slave modport  : the scheduler
//               master modport : requesters and result consumer
// Revision    : 1.0 - initial release
// ============================================================================
interface div11_rr_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
);
  import div11_rr_scheduler_pkg::*;

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*W-1:0]       req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    res_valid;
  logic                    res_ready;
  logic [W-1:0]            res_data;
  logic [id_w(NREQ)-1:0]   res_id;
  logic                    res_divisible;
  logic [CNT_W-1:0]        hit_count;
  logic                    busy;

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_data, res_id, res_divisible, hit_count, busy
  );

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_divisible, hit_count, busy
  );

endinterface
`default_nettype wire

// File: rtl/div11_rr_scheduler_div11.sv
`default_nettype none
// ============================================================================
// Module      : div11_rr_scheduler_div11
// Description : Combinational divisible-by-11 checker.
//               inp       - 16-bit unsigned word
//               divisible - 1 when inp mod 11 == 0 (0 counts as divisible)
// Revision    : 1.0 - initial release
// ============================================================================
module div11_rr_scheduler_div11
  import div11_rr_scheduler_pkg::*;
(
  input  wire logic [W-1:0] inp,
  output logic              divisible
);

  // Constant-divisor remainder; synthesis reduces this to a fixed network.
  assign divisible = ((inp % W'(11)) == '0);

endmodule
`default_nettype wire

// File: rtl/div11_rr_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : div11_rr_scheduler_rr_arbiter
// Description : Round-robin arbiter with a registered last-grant pointer.
//               clk, rst  - clock, synchronous active-high reset
//               req       - request vector
//               enable    - grant allowed this cycle
//               grant     - one-hot grant (all zero when none)
//               grant_idx - index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module div11_rr_scheduler_rr_arbiter
  import div11_rr_scheduler_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic [NREQ-1:0]        req,
  input  wire logic                   enable,
  output logic      [NREQ-1:0]        grant,
  output logic      [id_w(NREQ)-1:0]  grant_idx
);

  localparam int IW = id_w(NREQ);

  logic [IW-1:0] r_ptr;
  logic          w_any;
  int            w_idx;

  // Scan starts just after the last winner, so the winner drops to lowest
  // priority next time. Grants are suppressed during the reset cycle.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_any     = 1'b0;
    w_idx     = 0;
    if (enable && !rst) begin
      for (int off = 1; off <= NREQ; off++) begin
        w_idx = (int'(r_ptr) + off) % NREQ;
        if (!w_any && req[w_idx]) begin
          w_any        = 1'b1;
          grant[w_idx] = 1'b1;
          grant_idx    = IW'(w_idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= IW'(NREQ - 1);
    end else if (w_any) begin
      r_ptr <= grant_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/div11_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : div11_rr_scheduler
// Description : Shares one divisible-by-11 checker among NREQ requesters via
//               a round-robin arbiter; results land in a one-entry slot
//               tagged with requester id and word, and a saturating counter
//               tracks delivered divisible results.
//               clk, rst - clock, synchronous active-high reset
//               bus      - slave side of div11_rr_scheduler_if
// Revision    : 1.0 - initial release
// ============================================================================
module div11_rr_scheduler
  import div11_rr_scheduler_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
) (
  input  wire logic           clk,
  input  wire logic           rst,
  div11_rr_scheduler_if.slave bus
);

  localparam int IW = id_w(NREQ);

  logic [NREQ-1:0]  w_grant;
  logic [IW-1:0]    w_gidx;
  logic             w_slot_free;
  logic             w_accept;
  logic             w_deliver;
  logic             w_divisible;
  logic [W-1:0]     w_word;

  logic             r_res_valid;
  logic [W-1:0]     r_res_data;
  logic [IW-1:0]    r_res_id;
  logic             r_res_div;
  logic [CNT_W-1:0] r_hit;

  // The slot can take a new word when empty or when it drains this cycle,
  // which gives back-to-back results with no bubble.
  assign w_slot_free = ~r_res_valid | bus.res_ready;
  assign w_accept    = |w_grant;
  assign w_deliver   = r_res_valid & bus.res_ready;
  assign w_word      = bus.req_data[int'(w_gidx)*W +: W];

  div11_rr_scheduler_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .enable    (w_slot_free),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  div11_rr_scheduler_div11 u_div11 (
    .inp       (w_word),
    .divisible (w_divisible)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_res_div   <= 1'b0;
    end else if (w_accept) begin
      r_res_valid <= 1'b1;
      r_res_data  <= w_word;
      r_res_id    <= w_gidx;
      r_res_div   <= w_divisible;
    end else if (w_deliver) begin
      r_res_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit <= '0;
    end else if (w_deliver && r_res_div && (r_hit != '1)) begin
      r_hit <= r_hit + CNT_W'(1);
    end
  end

  assign bus.req_ready     = w_grant;
  assign bus.res_valid     = r_res_valid;
  assign bus.res_data      = r_res_data;
  assign bus.res_id        = r_res_id;
  assign bus.res_divisible = r_res_div;
  assign bus.hit_count     = r_hit;
  assign bus.busy          = r_res_valid & ~bus.res_ready;

endmodule
`default_nettype wire
